// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, two-state filter FSM
// and saturating stable-time counter, with registered rise/fall/any-change strobes.
module debounce_multi #(
    parameter int   C_CLKFREQ     = 100000000,
    parameter int   C_CHANNELS    = 4,
    parameter int   C_DEBOUNCE_MS = 1,
    parameter int   C_SYNC_STAGES = 2,
    parameter logic C_INIT        = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [C_CHANNELS-1:0] signal_i,
    output logic [C_CHANNELS-1:0] signal_o,
    output logic [C_CHANNELS-1:0] rise_o,
    output logic [C_CHANNELS-1:0] fall_o,
    output logic                  changed_o
);

    localparam int T  = (C_CLKFREQ / 1000) * C_DEBOUNCE_MS;
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(T - 1);

    if (C_CLKFREQ % 1000 != 0) begin : g_bad_clkfreq
        $fatal(1, "debounce_multi: C_CLKFREQ must be a multiple of 1000");
    end
    if (T < 1) begin : g_bad_window
        $fatal(1, "debounce_multi: debounce window must be at least one cycle");
    end
    if (C_SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "debounce_multi: C_SYNC_STAGES must be at least 2");
    end
    if (C_CHANNELS < 1 || C_CHANNELS > 32) begin : g_bad_channels
        $fatal(1, "debounce_multi: C_CHANNELS must be in 1..32");
    end

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } state_t;

    logic [C_CHANNELS-1:0] rise_next;
    logic [C_CHANNELS-1:0] fall_next;

    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
        logic [C_SYNC_STAGES-1:0] sync_q;
        logic                     s;
        state_t                   state_q, state_d;
        logic [CW-1:0]            cnt_q, cnt_d;
        logic                     out_q, out_d;
        logic                     rise_q, fall_q;
        logic                     rise_d, fall_d;

        assign s = sync_q[C_SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {C_SYNC_STAGES{C_INIT}};
            end else begin
                sync_q <= {sync_q[C_SYNC_STAGES-2:0], signal_i[i]};
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = out_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                ST_STABLE: begin
                    cnt_d = '0;
                    if (s != out_q) begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // A mismatch-free sample anywhere in the window discards all progress.
                    if (s == out_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == T_LAST) begin
                        out_d   = s;
                        rise_d  = s;
                        fall_d  = ~s;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                out_q   <= C_INIT;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign signal_o[i]  = out_q;
        assign rise_o[i]    = rise_q;
        assign fall_o[i]    = fall_q;
        assign rise_next[i] = rise_d;
        assign fall_next[i] = fall_d;
    end

    // Built from the pre-register pulses so it lands in the same cycle as rise_o/fall_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_o <= 1'b0;
        end else begin
            changed_o <= |(rise_next | fall_next);
        end
    end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Multi-channel, parametrised debouncer for mechanical switches and push-buttons. Each of `C_CHANNELS` asynchronous inputs is synchronised, then filtered by its own state machine and cycle counter. The cleaned level changes only after the input has held its new value for a configurable number of milliseconds. The block also emits per-channel single-cycle rise and fall pulses and an any-change strobe, and sits between board I/O pins and user control logic.

## Interface
Parameters:
- `C_CLKFREQ`, 100000000, clock frequency in Hz; must be a multiple of 1000.
- `C_CHANNELS`, 4, number of independent channels; valid range 1..32.
- `C_DEBOUNCE_MS`, 1, required stable time in ms; ≥1.
- `C_SYNC_STAGES`, 2, synchroniser flops per channel; ≥2.
- `C_INIT`, 1'b0, reset level of every channel's synchroniser and output.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low. Assertion takes effect immediately; deassertion is synchronised to `clk` at system level.
- `signal_i` input C_CHANNELS: raw asynchronous inputs.
- `signal_o` output C_CHANNELS: debounced levels, registered.
- `rise_o` output C_CHANNELS: 1-cycle pulse when `signal_o[i]` goes 0→1.
- `fall_o` output C_CHANNELS: 1-cycle pulse when `signal_o[i]` goes 1→0.
- `changed_o` output 1: registered OR of all `rise_o | fall_o`, aligned with them.

## Operation
- T = (C_CLKFREQ/1000)·C_DEBOUNCE_MS clock cycles.
  - Per-channel counter width is clog2(T).
  - The counter saturates at T-1 and never wraps.
- Synchroniser: each channel is a `C_SYNC_STAGES` flop chain. Its last flop is `s[i]`.
- Per-channel FSM has 2 states.
  - **STABLE**, counter held at 0.
    - If `s[i] != signal_o[i]`, go to PENDING with counter = 0.
  - **PENDING**, evaluated in this priority order:
    1. If `s[i] == signal_o[i]`: glitch rejected. Return to STABLE, counter = 0, no output change.
    2. Else if counter == T-1: `signal_o[i] <= s[i]`. Pulse `rise_o[i]` or `fall_o[i]` for that same registered cycle. Return to STABLE.
    3. Else: counter += 1.
- A rejected glitch fully restarts the window; there is no partial credit.
- Both edge directions use the same T. Behaviour is symmetric for 0→1 and 1→0.
- Channels are fully independent.
  - Simultaneous completions on several channels each pulse their own `rise_o`/`fall_o` in the same cycle.
  - `changed_o` is 1 for that cycle.
- Reset (asynchronous, at any time, including mid-PENDING):
  - All FSMs go to STABLE and all counters to 0.
  - All synchroniser flops and `signal_o` take `C_INIT`.
  - `rise_o`, `fall_o` and `changed_o` go to 0.
  - No pulse is generated on reset assertion or on the first cycles after deassertion.
- Invalid parameters (`C_CLKFREQ` % 1000 ≠ 0, T < 1, `C_SYNC_STAGES` < 2) stop elaboration with a fatal error.

## Timing
Edges are numbered relative to e0, the first edge that samples a new value on `signal_i[i]`.
- `s[i]` shows the new value after edge e(S-1), where S = `C_SYNC_STAGES`.
- PENDING is entered at edge eS.
- `signal_o[i]` and its pulse update at edge e(S+T), provided `s[i]` held the new value at every edge eS..e(S+T). That is T+1 consecutive samples.
- End-to-end latency is S+T cycles.
- `rise_o`/`fall_o` are high for exactly the one cycle after e(S+T). `changed_o` is coincident with them.
- The minimum spacing between two output changes on one channel is T+1 cycles. A second pulse therefore cannot occur before the first has ended.
- An input pulse shorter than T+1 clocks (after synchronisation) never reaches `signal_o`.

## Test plan
Default bench parameters: `C_CLKFREQ`=10000, `C_DEBOUNCE_MS`=1 (T=10), `C_CHANNELS`=4, `C_SYNC_STAGES`=2.
- Clean press: `signal_i[0]` goes 0→1 and is held. Required:
  - `signal_o[0]`=1 exactly 12 cycles after the first sampling edge.
  - `rise_o[0]` and `changed_o` high for 1 cycle.
  - Other channels unchanged.
- Bounce: on ch1, 1 for 5 cycles, 0 for 3, 1 for 9, 0 for 2, then 1 held. Required:
  - No output activity during the bounce.
  - `signal_o[1]` rises 12 cycles after the final 0→1 sample.
  - Exactly one `rise_o[1]` pulse.
- Release and boundary: ch2 is stable at 1 and goes 0 for exactly 10 sync'd cycles, then back to 1. Required: no change. Repeating with 11 cycles low gives `signal_o[2]`=0, one `fall_o[2]`, then a `rise_o[2]` T+1 cycles later once 1 is held.
- Simultaneous: ch0 and ch3 toggle on the same edge. Required: `rise_o`=4'b1001 in one cycle, with a single-cycle `changed_o`.
- Reset mid-PENDING:
  - Setup: ch0 is at count 6 when `rst_n` is pulled low between clock edges.
  - Required while low: outputs go to C_INIT immediately, with no clock needed.
  - Required after deassertion with `signal_i`=C_INIT: no pulses for 50 cycles.
  - Required when the input is held at 1: `signal_o[0]` rises a full 12 cycles after sampling.
- Parameter sweep: C_DEBOUNCE_MS=3, C_SYNC_STAGES=3, C_INIT=1. Required:
  - Latency = 33 cycles.
  - Outputs are 1 after reset with no spurious `fall_o`.
